// File: rtl/rvfi_cmp_pkg.sv
// rvfi_cmp_pkg
// Shared types and constants for the RVFI retirement comparator.
// One retirement is held as a packed struct. PC and rd write data are
// stored at CMP_MAX_XLEN bits, so the same entry type serves both 32-
// and 64-bit cores. Narrower values are zero-extended on the way in.
package rvfi_cmp_pkg;

  localparam int CMP_MAX_XLEN = 64;
  localparam int CMP_FIELDS   = 6;

  localparam int CMP_ORDER_BIT = 0;
  localparam int CMP_PC_BIT    = 1;
  localparam int CMP_INSN_BIT  = 2;
  localparam int CMP_TRAP_BIT  = 3;
  localparam int CMP_RD_BIT    = 4;
  localparam int CMP_WDATA_BIT = 5;

  typedef struct packed {
    logic [63:0]             order;
    logic [CMP_MAX_XLEN-1:0] pc;
    logic [31:0]             insn;
    logic                    trap;
    logic [4:0]              rd_addr;
    logic [CMP_MAX_XLEN-1:0] rd_wdata;
  } rvfi_cmp_entry_t;

  localparam int CMP_ENTRY_W = $bits(rvfi_cmp_entry_t);

  // Per-field mismatch mask. A write to x0 carries no architectural
  // data, so rd_wdata only counts when both sides name a real register.
  function automatic logic [CMP_FIELDS-1:0] cmp_fields(input rvfi_cmp_entry_t a,
                                                       input rvfi_cmp_entry_t b);
    logic [CMP_FIELDS-1:0] m;
    m                = '0;
    m[CMP_ORDER_BIT] = (a.order   != b.order);
    m[CMP_PC_BIT]    = (a.pc      != b.pc);
    m[CMP_INSN_BIT]  = (a.insn    != b.insn);
    m[CMP_TRAP_BIT]  = (a.trap    != b.trap);
    m[CMP_RD_BIT]    = (a.rd_addr != b.rd_addr);
    m[CMP_WDATA_BIT] = (a.rd_addr != 5'd0) && (b.rd_addr != 5'd0) &&
                       (a.rd_wdata != b.rd_wdata);
    return m;
  endfunction

endpackage

// File: rtl/rvfi_cmp_fifo.sv
// rvfi_cmp_fifo
// Synchronous FIFO that buffers DUT retirements until the reference
// model retires the matching instruction. The head is read
// combinationally, so a pop consumes the entry visible in the same cycle.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle. In that case the write lands in the slot that the pop is freeing.
module rvfi_cmp_fifo
  import rvfi_cmp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_push,
  input  logic [CMP_ENTRY_W-1:0]      i_push_data,
  input  logic                        i_pop,
  output logic [CMP_ENTRY_W-1:0]      o_head,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(DEPTH):0]      o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CMP_ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);

  // Storage array: written on an accepted push. It has no reset because
  // the pointers and count decide which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy. The pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/rvfi_retire_compare.sv
// rvfi_retire_compare
// In-order comparator between DUT RVFI retirements and the reference
// model. DUT retirements are buffered. Each reference retirement is
// checked against the oldest buffered one, or against the DUT retirement
// in the same cycle when the buffer is empty. Results, counters and
// sticky protocol errors are registered.
// Optional feature: define RVFI_CMP_TIMEOUT_EN to enable the head-of-queue
// timeout watchdog that drives err_timeout_o.
module rvfi_retire_compare
  import rvfi_cmp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     dut_valid_i,
  input  logic [63:0]              dut_order_i,
  input  logic [XLEN-1:0]          dut_pc_i,
  input  logic [31:0]              dut_insn_i,
  input  logic                     dut_trap_i,
  input  logic [4:0]               dut_rd_addr_i,
  input  logic [XLEN-1:0]          dut_rd_wdata_i,
  input  logic                     ref_valid_i,
  input  logic [63:0]              ref_order_i,
  input  logic [XLEN-1:0]          ref_pc_i,
  input  logic [31:0]              ref_insn_i,
  input  logic                     ref_trap_i,
  input  logic [4:0]               ref_rd_addr_i,
  input  logic [XLEN-1:0]          ref_rd_wdata_i,
  output logic                     cmp_valid_o,
  output logic                     cmp_match_o,
  output logic [5:0]               cmp_mask_o,
  output logic [63:0]              cmp_order_o,
  output logic [31:0]              match_cnt_o,
  output logic [31:0]              mismatch_cnt_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     err_overflow_o,
  output logic                     err_spurious_o,
  output logic                     err_timeout_o
);

  rvfi_cmp_entry_t w_dut_entry;
  rvfi_cmp_entry_t w_ref_entry;
  rvfi_cmp_entry_t w_head_entry;
  rvfi_cmp_entry_t w_cmp_src;

  logic [CMP_ENTRY_W-1:0]  w_head_bits;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [$clog2(DEPTH):0]  w_fifo_count;

  logic                    w_bypass;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_overflow;
  logic                    w_spurious;
  logic                    w_cmp_fire;
  logic [CMP_FIELDS-1:0]   w_cmp_mask;
  logic                    w_cmp_match;

  logic                    r_cmp_valid;
  logic                    r_cmp_match;
  logic [CMP_FIELDS-1:0]   r_cmp_mask;
  logic [63:0]             r_cmp_order;
  logic [31:0]             r_match_cnt;
  logic [31:0]             r_mismatch_cnt;
  logic                    r_err_overflow;
  logic                    r_err_spurious;

  // Pack both incoming retirements into the common entry layout.
  always_comb begin
    w_dut_entry          = '0;
    w_dut_entry.order    = dut_order_i;
    w_dut_entry.pc       = CMP_MAX_XLEN'(dut_pc_i);
    w_dut_entry.insn     = dut_insn_i;
    w_dut_entry.trap     = dut_trap_i;
    w_dut_entry.rd_addr  = dut_rd_addr_i;
    w_dut_entry.rd_wdata = CMP_MAX_XLEN'(dut_rd_wdata_i);
    w_ref_entry          = '0;
    w_ref_entry.order    = ref_order_i;
    w_ref_entry.pc       = CMP_MAX_XLEN'(ref_pc_i);
    w_ref_entry.insn     = ref_insn_i;
    w_ref_entry.trap     = ref_trap_i;
    w_ref_entry.rd_addr  = ref_rd_addr_i;
    w_ref_entry.rd_wdata = CMP_MAX_XLEN'(ref_rd_wdata_i);
  end

  // Neither side can be stalled, so push, pop, bypass and the error cases
  // are all decided combinationally from this cycle's valids and the
  // FIFO state.
  assign w_bypass   = w_fifo_empty & dut_valid_i & ref_valid_i;
  assign w_pop      = ref_valid_i & ~w_fifo_empty;
  assign w_push     = dut_valid_i & ~w_bypass & (~w_fifo_full | w_pop);
  assign w_overflow = dut_valid_i & w_fifo_full & ~w_pop;
  assign w_spurious = ref_valid_i & w_fifo_empty & ~dut_valid_i;
  assign w_cmp_fire = w_bypass | w_pop;

  assign w_head_entry = w_head_bits;
  assign w_cmp_src    = w_bypass ? w_dut_entry : w_head_entry;
  assign w_cmp_mask   = cmp_fields(w_cmp_src, w_ref_entry);
  assign w_cmp_match  = ~|w_cmp_mask;

  rvfi_cmp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .i_push      (w_push),
    .i_push_data (w_dut_entry),
    .i_pop       (w_pop),
    .o_head      (w_head_bits),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  // Register the comparison result. The valid pulse lasts one cycle, and
  // the result fields hold until the next compare.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cmp_valid <= 1'b0;
      r_cmp_match <= 1'b0;
      r_cmp_mask  <= '0;
      r_cmp_order <= '0;
    end else begin
      r_cmp_valid <= w_cmp_fire;
      if (w_cmp_fire) begin
        r_cmp_match <= w_cmp_match;
        r_cmp_mask  <= w_cmp_mask;
        r_cmp_order <= w_cmp_src.order;
      end
    end
  end

  // Saturating match and mismatch counters. They update on the same edge
  // that raises cmp_valid_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_match_cnt    <= '0;
      r_mismatch_cnt <= '0;
    end else if (w_cmp_fire) begin
      if (w_cmp_match && (r_match_cnt != 32'hFFFF_FFFF))
        r_match_cnt <= r_match_cnt + 32'd1;
      if (!w_cmp_match && (r_mismatch_cnt != 32'hFFFF_FFFF))
        r_mismatch_cnt <= r_mismatch_cnt + 32'd1;
    end
  end

  // Sticky protocol errors. Only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_overflow <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      if (w_overflow) r_err_overflow <= 1'b1;
      if (w_spurious) r_err_spurious <= 1'b1;
    end
  end

`ifdef RVFI_CMP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_err_timeout;

  // Age of the current head. It restarts whenever the head changes or the
  // FIFO drains, and it parks at TIMEOUT until the stuck entry moves.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_to_cnt <= '0;
    end else if (w_fifo_empty || w_pop) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_W'(TIMEOUT)) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Flag the timeout on the edge after the age counter reaches TIMEOUT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_timeout <= 1'b0;
    end else if (r_to_cnt == TO_W'(TIMEOUT)) begin
      r_err_timeout <= 1'b1;
    end
  end

  assign err_timeout_o = r_err_timeout;
`else
  assign err_timeout_o = 1'b0;
`endif

  assign cmp_valid_o    = r_cmp_valid;
  assign cmp_match_o    = r_cmp_match;
  assign cmp_mask_o     = r_cmp_mask;
  assign cmp_order_o    = r_cmp_order;
  assign match_cnt_o    = r_match_cnt;
  assign mismatch_cnt_o = r_mismatch_cnt;
  assign occupancy_o    = w_fifo_count;
  assign err_overflow_o = r_err_overflow;
  assign err_spurious_o = r_err_spurious;

endmodule

// File: tb/tb_rvfi_retire_compare.sv
// tb_rvfi_retire_compare
// Directed bench for rvfi_retire_compare with DEPTH=8 and TIMEOUT=16.
// Expected timeout behaviour follows RVFI_CMP_TIMEOUT_EN when it is
// defined for the build.
`timescale 1ns/1ps
module tb_rvfi_retire_compare;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        dut_valid_i;
  logic [63:0] dut_order_i;
  logic [31:0] dut_pc_i;
  logic [31:0] dut_insn_i;
  logic        dut_trap_i;
  logic [4:0]  dut_rd_addr_i;
  logic [31:0] dut_rd_wdata_i;
  logic        ref_valid_i;
  logic [63:0] ref_order_i;
  logic [31:0] ref_pc_i;
  logic [31:0] ref_insn_i;
  logic        ref_trap_i;
  logic [4:0]  ref_rd_addr_i;
  logic [31:0] ref_rd_wdata_i;
  logic        cmp_valid_o;
  logic        cmp_match_o;
  logic [5:0]  cmp_mask_o;
  logic [63:0] cmp_order_o;
  logic [31:0] match_cnt_o;
  logic [31:0] mismatch_cnt_o;
  logic [3:0]  occupancy_o;
  logic        err_overflow_o;
  logic        err_spurious_o;
  logic        err_timeout_o;

  int tests = 0;
  int fails = 0;
  int expMatch = 0;
  int expMismatch = 0;

  rvfi_retire_compare #(
    .XLEN    (32),
    .DEPTH   (8),
    .TIMEOUT (16)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .dut_valid_i    (dut_valid_i),
    .dut_order_i    (dut_order_i),
    .dut_pc_i       (dut_pc_i),
    .dut_insn_i     (dut_insn_i),
    .dut_trap_i     (dut_trap_i),
    .dut_rd_addr_i  (dut_rd_addr_i),
    .dut_rd_wdata_i (dut_rd_wdata_i),
    .ref_valid_i    (ref_valid_i),
    .ref_order_i    (ref_order_i),
    .ref_pc_i       (ref_pc_i),
    .ref_insn_i     (ref_insn_i),
    .ref_trap_i     (ref_trap_i),
    .ref_rd_addr_i  (ref_rd_addr_i),
    .ref_rd_wdata_i (ref_rd_wdata_i),
    .cmp_valid_o    (cmp_valid_o),
    .cmp_match_o    (cmp_match_o),
    .cmp_mask_o     (cmp_mask_o),
    .cmp_order_o    (cmp_order_o),
    .match_cnt_o    (match_cnt_o),
    .mismatch_cnt_o (mismatch_cnt_o),
    .occupancy_o    (occupancy_o),
    .err_overflow_o (err_overflow_o),
    .err_spurious_o (err_spurious_o),
    .err_timeout_o  (err_timeout_o)
  );

  // Free-running 10 ns clock.
  always #5 clk_i = ~clk_i;

  // Advance one edge, sample 1 ns after it, and drop both valids.
  task automatic step();
    @(posedge clk_i);
    #1;
    dut_valid_i = 1'b0;
    ref_valid_i = 1'b0;
  endtask

  task automatic drive_dut(input logic [63:0] o, input logic [31:0] pc, input logic [4:0] rd,
                           input logic [31:0] wd);
    dut_valid_i    = 1'b1;
    dut_order_i    = o;
    dut_pc_i       = pc;
    dut_insn_i     = 32'h0000_0013;
    dut_trap_i     = 1'b0;
    dut_rd_addr_i  = rd;
    dut_rd_wdata_i = wd;
  endtask

  task automatic drive_ref(input logic [63:0] o, input logic [31:0] pc, input logic [4:0] rd,
                           input logic [31:0] wd);
    ref_valid_i    = 1'b1;
    ref_order_i    = o;
    ref_pc_i       = pc;
    ref_insn_i     = 32'h0000_0013;
    ref_trap_i     = 1'b0;
    ref_rd_addr_i  = rd;
    ref_rd_wdata_i = wd;
  endtask

  // Canonical retirement for a given order number.
  task automatic drive_dut_ord(input int o);
    drive_dut(64'(o), 32'h8000_0000 + 32'((o - 1) * 4), 5'(o), 32'(o * 3));
  endtask

  task automatic drive_ref_ord(input int o);
    drive_ref(64'(o), 32'h8000_0000 + 32'((o - 1) * 4), 5'(o), 32'(o * 3));
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    tests++; if (cmp_valid_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %0h want 0", cmp_valid_o); end
    tests++; if (cmp_match_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_match: got %0h want 0", cmp_match_o); end
    tests++; if (cmp_mask_o !== 6'd0) begin fails++; $display("[TB] FAIL reset_mask: got %0h want 0", cmp_mask_o); end
    tests++; if (cmp_order_o !== 64'd0) begin fails++; $display("[TB] FAIL reset_order: got %0h want 0", cmp_order_o); end
    tests++; if (match_cnt_o !== 32'd0 || mismatch_cnt_o !== 32'd0) begin fails++; $display("[TB] FAIL reset_cnt: got %0d/%0d want 0/0", match_cnt_o, mismatch_cnt_o); end
    tests++; if (occupancy_o !== 4'd0) begin fails++; $display("[TB] FAIL reset_occ: got %0d want 0", occupancy_o); end
    tests++; if ({err_overflow_o, err_spurious_o, err_timeout_o} !== 3'b000) begin fails++; $display("[TB] FAIL reset_err: got %b want 000", {err_overflow_o, err_spurious_o, err_timeout_o}); end
  endtask

  task automatic test_in_order();
    for (int i = 1; i <= 3; i++) begin
      drive_dut_ord(i);
      step();
    end
    tests++; if (occupancy_o !== 4'd3) begin fails++; $display("[TB] FAIL inorder_occ3: got %0d want 3", occupancy_o); end
    repeat (5) step();
    for (int i = 1; i <= 3; i++) begin
      drive_ref_ord(i);
      step();
      expMatch++;
      tests++; if (cmp_valid_o !== 1'b1 || cmp_match_o !== 1'b1 || cmp_mask_o !== 6'd0) begin fails++; $display("[TB] FAIL inorder_cmp%0d: got v=%0b m=%0b mask=%b want 1 1 000000", i, cmp_valid_o, cmp_match_o, cmp_mask_o); end
      tests++; if (cmp_order_o !== 64'(i)) begin fails++; $display("[TB] FAIL inorder_order%0d: got %0d want %0d", i, cmp_order_o, i); end
    end
    tests++; if (match_cnt_o !== 32'd3) begin fails++; $display("[TB] FAIL inorder_cnt: got %0d want 3", match_cnt_o); end
    tests++; if (occupancy_o !== 4'd0) begin fails++; $display("[TB] FAIL inorder_occ0: got %0d want 0", occupancy_o); end
    step();
    tests++; if (cmp_valid_o !== 1'b0) begin fails++; $display("[TB] FAIL inorder_pulse: got %0b want 0", cmp_valid_o); end
  endtask

  task automatic test_wdata();
    drive_dut(64'd4, 32'h8000_000C, 5'd3, 32'h6);
    step();
    drive_ref(64'd4, 32'h8000_000C, 5'd3, 32'h5);
    step();
    expMismatch++;
    tests++; if (cmp_valid_o !== 1'b1 || cmp_match_o !== 1'b0 || cmp_mask_o !== 6'b100000) begin fails++; $display("[TB] FAIL wdata_mask: got v=%0b m=%0b mask=%b want 1 0 100000", cmp_valid_o, cmp_match_o, cmp_mask_o); end
    tests++; if (mismatch_cnt_o !== 32'(expMismatch)) begin fails++; $display("[TB] FAIL wdata_mcnt: got %0d want %0d", mismatch_cnt_o, expMismatch); end
    drive_dut(64'd5, 32'h8000_0010, 5'd0, 32'h6);
    step();
    drive_ref(64'd5, 32'h8000_0010, 5'd0, 32'h5);
    step();
    expMatch++;
    tests++; if (cmp_valid_o !== 1'b1 || cmp_match_o !== 1'b1 || cmp_mask_o !== 6'd0) begin fails++; $display("[TB] FAIL wdata_x0: got v=%0b m=%0b mask=%b want 1 1 000000", cmp_valid_o, cmp_match_o, cmp_mask_o); end
    tests++; if (match_cnt_o !== 32'(expMatch)) begin fails++; $display("[TB] FAIL wdata_cnt: got %0d want %0d", match_cnt_o, expMatch); end
  endtask

  task automatic test_bypass();
    drive_dut_ord(6);
    drive_ref_ord(6);
    step();
    expMatch++;
    tests++; if (cmp_valid_o !== 1'b1 || cmp_match_o !== 1'b1 || cmp_order_o !== 64'd6) begin fails++; $display("[TB] FAIL bypass_match: got v=%0b m=%0b ord=%0d want 1 1 6", cmp_valid_o, cmp_match_o, cmp_order_o); end
    tests++; if (occupancy_o !== 4'd0) begin fails++; $display("[TB] FAIL bypass_occ: got %0d want 0", occupancy_o); end
    drive_dut_ord(7);
    drive_ref(64'd7, 32'h1234_0000, 5'd7, 32'd21);
    step();
    expMismatch++;
    tests++; if (cmp_valid_o !== 1'b1 || cmp_mask_o !== 6'b000010) begin fails++; $display("[TB] FAIL bypass_pc: got v=%0b mask=%b want 1 000010", cmp_valid_o, cmp_mask_o); end
    tests++; if (match_cnt_o !== 32'(expMatch) || mismatch_cnt_o !== 32'(expMismatch)) begin fails++; $display("[TB] FAIL bypass_cnt: got %0d/%0d want %0d/%0d", match_cnt_o, mismatch_cnt_o, expMatch, expMismatch); end
  endtask

  task automatic test_overflow();
    for (int i = 10; i <= 17; i++) begin
      drive_dut_ord(i);
      step();
    end
    tests++; if (occupancy_o !== 4'd8 || err_overflow_o !== 1'b0) begin fails++; $display("[TB] FAIL full_state: got occ=%0d ovf=%0b want 8 0", occupancy_o, err_overflow_o); end
    drive_dut_ord(18);
    drive_ref_ord(10);
    step();
    expMatch++;
    tests++; if (cmp_valid_o !== 1'b1 || cmp_match_o !== 1'b1 || cmp_order_o !== 64'd10) begin fails++; $display("[TB] FAIL full_pushpop_cmp: got v=%0b m=%0b ord=%0d want 1 1 10", cmp_valid_o, cmp_match_o, cmp_order_o); end
    tests++; if (occupancy_o !== 4'd8 || err_overflow_o !== 1'b0) begin fails++; $display("[TB] FAIL full_pushpop_state: got occ=%0d ovf=%0b want 8 0", occupancy_o, err_overflow_o); end
    drive_dut_ord(19);
    step();
    tests++; if (err_overflow_o !== 1'b1 || occupancy_o !== 4'd8) begin fails++; $display("[TB] FAIL overflow: got ovf=%0b occ=%0d want 1 8", err_overflow_o, occupancy_o); end
    for (int i = 11; i <= 18; i++) begin
      drive_ref_ord(i);
      step();
      expMatch++;
      tests++; if (cmp_valid_o !== 1'b1 || cmp_match_o !== 1'b1 || cmp_order_o !== 64'(i)) begin fails++; $display("[TB] FAIL drain%0d: got v=%0b m=%0b ord=%0d want 1 1 %0d", i, cmp_valid_o, cmp_match_o, cmp_order_o, i); end
    end
    tests++; if (occupancy_o !== 4'd0 || match_cnt_o !== 32'(expMatch)) begin fails++; $display("[TB] FAIL drain_end: got occ=%0d cnt=%0d want 0 %0d", occupancy_o, match_cnt_o, expMatch); end
    tests++; if (err_overflow_o !== 1'b1) begin fails++; $display("[TB] FAIL overflow_sticky: got %0b want 1", err_overflow_o); end
  endtask

  task automatic test_spurious();
    tests++; if (err_spurious_o !== 1'b0) begin fails++; $display("[TB] FAIL spurious_pre: got %0b want 0", err_spurious_o); end
    drive_ref_ord(30);
    step();
    tests++; if (err_spurious_o !== 1'b1 || cmp_valid_o !== 1'b0) begin fails++; $display("[TB] FAIL spurious: got err=%0b v=%0b want 1 0", err_spurious_o, cmp_valid_o); end
    tests++; if (mismatch_cnt_o !== 32'(expMismatch) || match_cnt_o !== 32'(expMatch)) begin fails++; $display("[TB] FAIL spurious_cnt: got %0d/%0d want %0d/%0d", match_cnt_o, mismatch_cnt_o, expMatch, expMismatch); end
  endtask

  task automatic test_timeout();
    logic expTo;
`ifdef RVFI_CMP_TIMEOUT_EN
    expTo = 1'b1;
`else
    expTo = 1'b0;
`endif
    drive_dut_ord(40);
    step();
    repeat (16) step();
    tests++; if (err_timeout_o !== 1'b0) begin fails++; $display("[TB] FAIL timeout_early: got %0b want 0", err_timeout_o); end
    step();
    tests++; if (err_timeout_o !== expTo) begin fails++; $display("[TB] FAIL timeout_rise: got %0b want %0b", err_timeout_o, expTo); end
    tests++; if (occupancy_o !== 4'd1) begin fails++; $display("[TB] FAIL timeout_occ: got %0d want 1", occupancy_o); end
  endtask

  task automatic test_reset_mid();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    tests++; if (occupancy_o !== 4'd0 || cmp_valid_o !== 1'b0 || cmp_mask_o !== 6'd0 || cmp_order_o !== 64'd0 || cmp_match_o !== 1'b0) begin fails++; $display("[TB] FAIL midreset_cmp: got occ=%0d v=%0b m=%0b mask=%b ord=%0d want all 0", occupancy_o, cmp_valid_o, cmp_match_o, cmp_mask_o, cmp_order_o); end
    tests++; if (match_cnt_o !== 32'd0 || mismatch_cnt_o !== 32'd0) begin fails++; $display("[TB] FAIL midreset_cnt: got %0d/%0d want 0/0", match_cnt_o, mismatch_cnt_o); end
    tests++; if ({err_overflow_o, err_spurious_o, err_timeout_o} !== 3'b000) begin fails++; $display("[TB] FAIL midreset_err: got %b want 000", {err_overflow_o, err_spurious_o, err_timeout_o}); end
    drive_ref_ord(40);
    step();
    tests++; if (err_spurious_o !== 1'b1 || cmp_valid_o !== 1'b0) begin fails++; $display("[TB] FAIL midreset_flush: got err=%0b v=%0b want 1 0", err_spurious_o, cmp_valid_o); end
  endtask

  // Run every scenario in sequence, then print the summary.
  initial begin
    rst_i = 1'b1;
    dut_valid_i = 1'b0; dut_order_i = '0; dut_pc_i = '0; dut_insn_i = '0;
    dut_trap_i = 1'b0; dut_rd_addr_i = '0; dut_rd_wdata_i = '0;
    ref_valid_i = 1'b0; ref_order_i = '0; ref_pc_i = '0; ref_insn_i = '0;
    ref_trap_i = 1'b0; ref_rd_addr_i = '0; ref_rd_wdata_i = '0;
    test_reset();
    test_in_order();
    test_wdata();
    test_bypass();
    test_overflow();
    test_spurious();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
